// File: rtl/i2c_wb_if_if.sv
// Host command / response port and Wishbone master bus of i2c_wb_if.
// The master modport is the bridge's view; slave is the host + Wishbone slave side.
interface i2c_wb_if_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_adr;
  logic [DATA_WIDTH-1:0] cmd_dat;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_dat;
  logic                  cyc_o;
  logic                  stb_o;
  logic                  we_o;
  logic [ADDR_WIDTH-1:0] adr_o;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  ack_i;
  logic [DATA_WIDTH-1:0] dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, ack_i, dat_i,
    output cmd_ready, rsp_valid, rsp_dat, cyc_o, stb_o, we_o, adr_o, dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, ack_i, dat_i,
    input  cmd_ready, rsp_valid, rsp_dat, cyc_o, stb_o, we_o, adr_o, dat_o
  );
endinterface

// File: rtl/i2c_wb_if.sv
// Host-command Wishbone master plus an I2C slave byte engine sharing one clock.
//
// state      | meaning
// WB_IDLE    | ready for a host command
// WB_BUS     | Wishbone cycle open, waiting for ack_i
// WB_DONE    | one-cycle rsp_valid
// I_IDLE     | bus free, waiting for START
// I_ADDR     | shifting address + R/W
// I_ACK_A    | pulling SDA low for the address ACK
// I_WRITE    | shifting a write byte from the master
// I_ACK_W    | pulling SDA low for the data ACK
// I_RD_REQ   | rd_req high, user prepares rd_byte
// I_RD_LOAD  | rd_byte captured into the shifter
// I_READ     | driving a read byte MSB first
// I_ACK_R    | SDA released, sampling master ACK/NACK
// I_IGNORE   | not addressed or NACKed, wait for START/STOP
module i2c_wb_if #(
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR = 7'h22
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      irq_i,
  output logic                      irq_pulse,
  i2c_wb_if_if.master               wb,
  input  logic                      scl,
  input  logic                      sda_i,
  output logic                      sda_o,
  output logic                      i2c_start,
  output logic                      i2c_stop,
  output logic                      i2c_op,
  output logic                      wr_valid,
  output logic [I2C_DATA_WIDTH-1:0] wr_byte,
  output logic                      rd_req,
  input  logic [I2C_DATA_WIDTH-1:0] rd_byte
);
  localparam logic [3:0] BIT_LAST = 4'(I2C_DATA_WIDTH);

  typedef enum logic [1:0] {WB_IDLE, WB_BUS, WB_DONE} wb_state_t;
  typedef enum logic [3:0] {
    I_IDLE, I_ADDR, I_ACK_A, I_WRITE, I_ACK_W,
    I_RD_REQ, I_RD_LOAD, I_READ, I_ACK_R, I_IGNORE
  } i_state_t;

  wb_state_t             wb_state, wb_next;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] adr_r;
  logic [DATA_WIDTH-1:0] dat_r;
  logic [DATA_WIDTH-1:0] rsp_r;
  logic                  irq_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) wb_state <= WB_IDLE;
    else       wb_state <= wb_next;
  end

  always_comb begin
    wb_next = wb_state;
    case (wb_state)
      WB_IDLE: if (wb.cmd_valid) wb_next = WB_BUS;
      WB_BUS:  if (wb.ack_i)     wb_next = WB_DONE;
      default:                   wb_next = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_r  <= 1'b0;
      adr_r <= '0;
      dat_r <= '0;
      rsp_r <= '0;
    end else begin
      if (wb_state == WB_IDLE && wb.cmd_valid) begin
        we_r  <= wb.cmd_we;
        adr_r <= wb.cmd_adr;
        dat_r <= wb.cmd_dat;
      end
      if (wb_state == WB_BUS && wb.ack_i && !we_r) rsp_r <= wb.dat_i;
    end
  end

  always_comb begin
    wb.cmd_ready = (wb_state == WB_IDLE);
    wb.cyc_o     = (wb_state == WB_BUS);
    wb.stb_o     = (wb_state == WB_BUS);
    wb.rsp_valid = (wb_state == WB_DONE);
    wb.we_o      = we_r;
    wb.adr_o     = adr_r;
    wb.dat_o     = dat_r;
    wb.rsp_dat   = rsp_r;
  end

  // Reset to 1 so an irq_i already high through reset does not pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) irq_q <= 1'b1;
    else       irq_q <= irq_i;
  end
  assign irq_pulse = irq_i & ~irq_q;

  logic scl_m, scl_s, scl_q, sda_m, sda_s, sda_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {scl_m, scl_s, scl_q} <= 3'b111;
      {sda_m, sda_s, sda_q} <= 3'b111;
    end else begin
      {scl_m, scl_s, scl_q} <= {scl, scl_m, scl_s};
      {sda_m, sda_s, sda_q} <= {sda_i, sda_m, sda_s};
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det, addr_hit;
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

  i_state_t                  i_state, i_next;
  logic [I2C_DATA_WIDTH-1:0] shreg;
  logic [3:0]                bit_cnt;
  logic                      m_nack;

  assign addr_hit = (shreg[I2C_DATA_WIDTH-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDR);

  always_ff @(posedge clk_i) begin
    if (rst_i) i_state <= I_IDLE;
    else       i_state <= i_next;
  end

  always_comb begin
    i_next = i_state;
    if (stop_det)       i_next = I_IDLE;
    else if (start_det) i_next = I_ADDR;
    else begin
      case (i_state)
        I_ADDR:    if (scl_fall && bit_cnt == BIT_LAST) i_next = addr_hit ? I_ACK_A : I_IGNORE;
        I_ACK_A:   if (scl_fall) i_next = i2c_op ? I_RD_REQ : I_WRITE;
        I_WRITE:   if (scl_fall && bit_cnt == BIT_LAST) i_next = I_ACK_W;
        I_ACK_W:   if (scl_fall) i_next = I_WRITE;
        I_RD_REQ:  i_next = I_RD_LOAD;
        I_RD_LOAD: i_next = I_READ;
        I_READ:    if (scl_fall && bit_cnt == BIT_LAST) i_next = I_ACK_R;
        I_ACK_R:   if (scl_fall) i_next = m_nack ? I_IGNORE : I_RD_REQ;
        default:   i_next = i_state;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      m_nack    <= 1'b0;
      i2c_op    <= 1'b0;
      wr_byte   <= '0;
      wr_valid  <= 1'b0;
      i2c_start <= 1'b0;
      i2c_stop  <= 1'b0;
    end else begin
      wr_valid  <= 1'b0;
      i2c_start <= start_det;
      i2c_stop  <= stop_det;
      if (start_det || stop_det) begin
        bit_cnt <= '0;
      end else begin
        case (i_state)
          I_ADDR, I_WRITE: begin
            if (scl_rise) begin
              shreg   <= {shreg[I2C_DATA_WIDTH-2:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end
            if (scl_fall && bit_cnt == BIT_LAST) begin
              if (i_state == I_ADDR && addr_hit) i2c_op <= shreg[0];
              if (i_state == I_WRITE) begin
                wr_byte  <= shreg;
                wr_valid <= 1'b1;
              end
            end
          end
          I_ACK_A, I_ACK_W: if (scl_fall) bit_cnt <= '0;
          I_RD_LOAD: begin
            shreg   <= rd_byte;
            bit_cnt <= '0;
          end
          I_READ: begin
            if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
            if (scl_fall) shreg <= {shreg[I2C_DATA_WIDTH-2:0], 1'b0};
          end
          I_ACK_R: if (scl_rise) m_nack <= sda_s;
          default: ;
        endcase
      end
    end
  end

  // Outputs follow state, which only moves on a synchronized SCL fall.
  always_comb begin
    rd_req = (i_state == I_RD_REQ);
    case (i_state)
      I_ACK_A, I_ACK_W: sda_o = 1'b0;
      I_READ:           sda_o = shreg[I2C_DATA_WIDTH-1];
      default:          sda_o = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_i2c_wb_if.sv
// Self-checking bench for i2c_wb_if: Wishbone command path, irq edge, I2C slave.
module tb_i2c_wb_if;
  localparam int Q = 4;
  localparam logic [6:0] SA = 7'h22;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq = 1'b0;
  logic irq_pulse;
  logic scl_m = 1'b1, sda_m = 1'b1;
  logic sda_bus, sda_o, i2c_start, i2c_stop, i2c_op, wr_valid, rd_req;
  logic [7:0] wr_byte, rd_byte;

  int checks = 0, failures = 0;
  int wr_cnt = 0, rd_cnt = 0, start_cnt = 0, stop_cnt = 0, rsp_cnt = 0, cyc_rise = 0, low_cnt = 0;
  int rd_seed = 0, rd_mark = 0, n_cmds = 0;
  logic cyc_prev = 1'b0;
  logic [7:0] exp_rsp = 8'h00;
  logic [7:0] wr_q[$];

  always #5 clk = ~clk;
  assign sda_bus = sda_m & sda_o;

  i2c_wb_if_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus();

  i2c_wb_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .I2C_ADDR_WIDTH(7), .I2C_DATA_WIDTH(8), .SLAVE_ADDR(SA)) dut (
    .clk_i(clk), .rst_i(rst), .irq_i(irq), .irq_pulse(irq_pulse), .wb(bus.master),
    .scl(scl_m), .sda_i(sda_bus), .sda_o(sda_o), .i2c_start(i2c_start), .i2c_stop(i2c_stop),
    .i2c_op(i2c_op), .wr_valid(wr_valid), .wr_byte(wr_byte), .rd_req(rd_req), .rd_byte(rd_byte)
  );

  always @(negedge clk) begin
    if (wr_valid) begin wr_q.push_back(wr_byte); wr_cnt++; end
    if (rd_req) begin rd_byte = 8'(rd_seed + rd_cnt - rd_mark); rd_cnt++; end
    if (i2c_start) start_cnt++;
    if (i2c_stop) stop_cnt++;
    if (bus.rsp_valid) rsp_cnt++;
    if (!sda_o) low_cnt++;
    if (bus.cyc_o && !cyc_prev) cyc_rise++;
    cyc_prev = bus.cyc_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; irq = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_we = 1'b1; bus.cmd_adr = 2'd3; bus.cmd_dat = 8'hFF;
    bus.ack_i = 1'b0; bus.dat_i = 8'h00;
    clk_wait(3);
    checks++;
    if ({bus.cmd_ready, bus.cyc_o, bus.stb_o, bus.we_o} !== 4'b1000) begin
      failures++; $display("FAIL reset_wb_ctl: got %b want 1000", {bus.cmd_ready, bus.cyc_o, bus.stb_o, bus.we_o});
    end
    checks++;
    if ({bus.adr_o, bus.dat_o, bus.rsp_valid, bus.rsp_dat} !== 19'd0) begin
      failures++; $display("FAIL reset_wb_data: got adr=%h dat=%h rv=%b rd=%h want zeros", bus.adr_o, bus.dat_o, bus.rsp_valid, bus.rsp_dat);
    end
    checks++;
    if ({sda_o, i2c_start, i2c_stop, wr_valid, rd_req, irq_pulse} !== 6'b100000) begin
      failures++; $display("FAIL reset_i2c: got %b want 100000", {sda_o, i2c_start, i2c_stop, wr_valid, rd_req, irq_pulse});
    end
    bus.cmd_valid = 1'b0; irq = 1'b0;
    clk_wait(1);
    rst = 1'b0;
    clk_wait(6);
    checks++;
    if (start_cnt !== 0 || stop_cnt !== 0 || cyc_rise !== 0) begin
      failures++; $display("FAIL reset_release: got start=%0d stop=%0d cyc=%0d want 0 0 0", start_cnt, stop_cnt, cyc_rise);
    end
  endtask

  task automatic wb_cmd(input logic we, input logic [1:0] adr, input logic [7:0] dat,
                        input int delay, input logic [7:0] sdat, input bit spam);
    logic [13:0] exp_o, got_o;
    int bad = 0;
    bus.cmd_valid = 1'b1; bus.cmd_we = we; bus.cmd_adr = adr; bus.cmd_dat = dat;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL wb_ready_idle: got %b want 1", bus.cmd_ready); end
    clk_wait(1);
    bus.cmd_valid = spam;
    if (spam) begin bus.cmd_we = ~we; bus.cmd_adr = ~adr; bus.cmd_dat = ~dat; end
    exp_o = {1'b0, 1'b1, 1'b1, we, adr, dat};
    for (int i = 0; i <= delay; i++) begin
      if (i == delay) begin bus.ack_i = 1'b1; bus.dat_i = sdat; end
      else bus.dat_i = 8'($urandom);
      got_o = {bus.cmd_ready, bus.cyc_o, bus.stb_o, bus.we_o, bus.adr_o, bus.dat_o};
      if (got_o !== exp_o) bad++;
      if (i != delay) clk_wait(1);
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL wb_hold: got %h want %h (%0d bad cycles)", got_o, exp_o, bad); end
    clk_wait(1);
    bus.ack_i = 1'b0; bus.cmd_valid = 1'b0;
    if (!we) exp_rsp = sdat;
    checks++;
    if ({bus.cyc_o, bus.stb_o, bus.rsp_valid, bus.rsp_dat} !== {3'b001, exp_rsp}) begin
      failures++; $display("FAIL wb_done: got cyc=%b stb=%b rv=%b rd=%h want 0 0 1 %h",
                           bus.cyc_o, bus.stb_o, bus.rsp_valid, bus.rsp_dat, exp_rsp);
    end
    clk_wait(1);
    checks++;
    if ({bus.rsp_valid, bus.cmd_ready, bus.rsp_dat} !== {2'b01, exp_rsp}) begin
      failures++; $display("FAIL wb_after: got rv=%b rdy=%b rd=%h want 0 1 %h", bus.rsp_valid, bus.cmd_ready, bus.rsp_dat, exp_rsp);
    end
    n_cmds++;
  endtask

  task automatic test_wishbone();
    int c0 = cyc_rise, r0 = rsp_cnt, n0 = n_cmds;
    wb_cmd(1'b1, 2'd0, 8'hC0, 3, 8'h5A, 1'b0);
    wb_cmd(1'b0, 2'd2, 8'h00, 2, 8'h80, 1'b0);
    for (int k = 0; k < 10; k++)
      wb_cmd(1'($urandom), 2'($urandom), 8'($urandom), $urandom_range(0, 4), 8'($urandom), 1'($urandom));
    checks++;
    if (cyc_rise - c0 !== n_cmds - n0 || rsp_cnt - r0 !== n_cmds - n0) begin
      failures++; $display("FAIL wb_one_cycle_per_cmd: got cyc=%0d rsp=%0d want %0d", cyc_rise - c0, rsp_cnt - r0, n_cmds - n0);
    end
  endtask

  task automatic test_irq();
    logic prev = irq;
    int bad = 0, seen = 0, want = 0;
    for (int i = 0; i < 60; i++) begin
      irq = 1'($urandom);
      #2;
      if (irq_pulse !== (irq & ~prev)) bad++;
      if (irq & ~prev) want++;
      if (irq_pulse === 1'b1) seen++;
      clk_wait(1);
      prev = irq;
    end
    irq = 1'b0;
    checks++;
    if (bad != 0 || seen != want) begin failures++; $display("FAIL irq_pulse: got %0d pulses want %0d (%0d bad)", seen, want, bad); end
  endtask

  task automatic i2c_bit(input logic b, output logic seen);
    scl_m = 1'b0; clk_wait(Q);
    sda_m = b;    clk_wait(Q);
    scl_m = 1'b1; clk_wait(Q);
    seen = sda_bus; clk_wait(Q);
  endtask

  task automatic i2c_start_c();
    scl_m = 1'b0; clk_wait(Q);
    sda_m = 1'b1; clk_wait(Q);
    scl_m = 1'b1; clk_wait(2*Q);
    sda_m = 1'b0; clk_wait(2*Q);
  endtask

  task automatic i2c_stop_c();
    scl_m = 1'b0; clk_wait(Q);
    sda_m = 1'b0; clk_wait(Q);
    scl_m = 1'b1; clk_wait(2*Q);
    sda_m = 1'b1; clk_wait(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
    i2c_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin i2c_bit(1'b1, s); b[i] = s; end
    i2c_bit(nack, s);
  endtask

  task automatic i2c_write_xfer(input int n, input bit rnd);
    logic [7:0] sent[$];
    logic ack;
    int nack_cnt = 0, bad = 0;
    int w0 = wr_cnt, s0 = start_cnt, p0 = stop_cnt, q0 = wr_q.size();
    i2c_start_c();
    send_byte({SA, 1'b0}, ack);
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL i2c_wr_addr_ack: got %b want 0", ack); end
    for (int i = 0; i < n; i++) begin
      sent.push_back(rnd ? 8'($urandom) : 8'(i));
      send_byte(sent[i], ack);
      if (ack !== 1'b0) nack_cnt++;
      if (i == 0) begin
        checks++;
        if (i2c_op !== 1'b0) begin failures++; $display("FAIL i2c_op_write: got %b want 0", i2c_op); end
      end
    end
    i2c_stop_c();
    checks++;
    if (nack_cnt != 0) begin failures++; $display("FAIL i2c_wr_data_ack: got %0d NACKs want 0", nack_cnt); end
    checks++;
    if (wr_cnt - w0 !== n) begin failures++; $display("FAIL i2c_wr_count: got %0d want %0d", wr_cnt - w0, n); end
    for (int i = 0; i < n && q0 + i < wr_q.size(); i++) if (wr_q[q0 + i] !== sent[i]) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL i2c_wr_bytes: got %0d wrong bytes want 0", bad); end
    checks++;
    if (start_cnt - s0 !== 1 || stop_cnt - p0 !== 1) begin
      failures++; $display("FAIL i2c_wr_conditions: got start=%0d stop=%0d want 1 1", start_cnt - s0, stop_cnt - p0);
    end
  endtask

  task automatic test_i2c_write();
    i2c_write_xfer(32, 1'b0);
    i2c_write_xfer($urandom_range(2, 6), 1'b1);
  endtask

  task automatic test_i2c_read(input int seed);
    logic ack;
    logic [7:0] b;
    int bad = 0;
    int r0 = rd_cnt;
    rd_seed = seed; rd_mark = rd_cnt;
    i2c_start_c();
    send_byte({SA, 1'b1}, ack);
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL i2c_rd_addr_ack: got %b want 0", ack); end
    checks++;
    if (i2c_op !== 1'b1) begin failures++; $display("FAIL i2c_op_read: got %b want 1", i2c_op); end
    for (int j = 0; j < 32; j++) begin
      recv_byte(j == 31, b);
      if (b !== 8'(seed + j)) begin
        bad++;
        if (bad == 1) $display("FAIL i2c_rd_byte: byte %0d got %h want %h", j, b, 8'(seed + j));
      end
    end
    i2c_stop_c();
    checks++;
    if (bad != 0) begin failures++; $display("FAIL i2c_rd_bytes: got %0d wrong bytes want 0", bad); end
    checks++;
    if (rd_cnt - r0 !== 32) begin failures++; $display("FAIL i2c_rd_req_count: got %0d want 32", rd_cnt - r0); end
  endtask

  task automatic test_i2c_badaddr();
    logic ack;
    logic [7:0] b = 8'($urandom);
    int l0 = low_cnt, w0 = wr_cnt, r0 = rd_cnt;
    i2c_start_c();
    send_byte({7'h23, 1'b0}, ack);
    checks++;
    if (ack !== 1'b1) begin failures++; $display("FAIL i2c_bad_addr_ack: got %b want 1", ack); end
    send_byte(8'h55, ack);
    checks++;
    if (low_cnt - l0 !== 0 || wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0) begin
      failures++; $display("FAIL i2c_bad_addr_quiet: got low=%0d wr=%0d rd=%0d want 0 0 0", low_cnt - l0, wr_cnt - w0, rd_cnt - r0);
    end
    i2c_start_c();
    send_byte({SA, 1'b0}, ack);
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL i2c_rep_start_ack: got %b want 0", ack); end
    send_byte(b, ack);
    i2c_stop_c();
    checks++;
    if (wr_cnt - w0 !== 1 || wr_q[wr_q.size() - 1] !== b) begin
      failures++; $display("FAIL i2c_rep_start_byte: got %0d bytes last=%h want 1 %h", wr_cnt - w0, wr_q[wr_q.size() - 1], b);
    end
  endtask

  task automatic test_reset_mid();
    logic s;
    int r0 = rsp_cnt;
    bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_adr = 2'd1; bus.cmd_dat = 8'h00;
    clk_wait(1);
    bus.cmd_valid = 1'b0;
    i2c_start_c();
    for (int i = 7; i >= 0; i--) i2c_bit(i == 0 ? 1'b0 : SA[i-1], s);
    scl_m = 1'b0; sda_m = 1'b1;
    clk_wait(6);
    checks++;
    if ({bus.cyc_o, sda_o} !== 2'b10) begin failures++; $display("FAIL mid_pre: got cyc=%b sda=%b want 1 0", bus.cyc_o, sda_o); end
    rst = 1'b1;
    clk_wait(1);
    checks++;
    if ({bus.cyc_o, bus.stb_o, sda_o, bus.cmd_ready} !== 4'b0011) begin
      failures++; $display("FAIL mid_reset: got cyc=%b stb=%b sda=%b rdy=%b want 0 0 1 1", bus.cyc_o, bus.stb_o, sda_o, bus.cmd_ready);
    end
    rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    clk_wait(12);
    checks++;
    if (rsp_cnt - r0 !== 0 || bus.cyc_o !== 1'b0) begin
      failures++; $display("FAIL mid_no_rsp: got rsp=%0d cyc=%b want 0 0", rsp_cnt - r0, bus.cyc_o);
    end
    exp_rsp = 8'h00;
    wb_cmd(1'b0, 2'd3, 8'h00, 1, 8'h3C, 1'b0);
  endtask

  initial begin
    test_reset();
    test_wishbone();
    test_irq();
    test_i2c_write();
    test_i2c_read(100);
    test_i2c_read($urandom_range(0, 255));
    test_i2c_badaddr();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
